// File: rtl/multicycle_control.sv
// -----------------------------------------------------------------------------
// multicycle_control
//
// Moore-style control FSM for the multicycle MIPS datapath. Each instruction
// walks through FETCH / DECODE / execute / memory / writeback steps, and the
// datapath enables are decoded from the current state.
//
// Parameters
//   ALUOP_W  width of alu_op (>= 2). Codes are zero-extended:
//            0 = add, 1 = sub, 2 = use funct field.
//   ADDI_EN  1 = addi (6'b001000) is decoded, 0 = addi traps as illegal.
//   CNT_W    width of the performance counters (optional feature only).
//
// Optional feature
//   `define MULTICYCLE_CTRL_PERF_EN adds the instr_count / stall_count
//   outputs. Without the macro those ports and counters do not exist.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   opcode[5:0]     IR[31:26], stable from DECODE onward
//   mem_ready       memory completes the requested access this cycle
//   pc_write        unconditional PC load
//   pc_write_cond   PC load if ALU zero (beq)
//   i_or_d          memory address select: 0 = PC, 1 = ALUOut
//   mem_read        memory read request
//   mem_write       memory write request
//   ir_write        instruction register load
//   mem_to_reg      register write data: 1 = MDR, 0 = ALUOut
//   reg_dst         write register: 1 = rd, 0 = rt
//   reg_write       register file write enable
//   alu_src_a       ALU A: 0 = PC, 1 = A register
//   alu_src_b[1:0]  ALU B: 0 = B, 1 = 4, 2 = signext imm, 3 = signext imm<<2
//   alu_op          ALU operation class
//   pc_source[1:0]  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
//   illegal_op      one-cycle pulse while the TRAP state is active
//   state[3:0]      current state encoding (debug)
//   instr_count     (optional) instructions retired, wraps mod 2^CNT_W
//   stall_count     (optional) cycles waiting on memory, wraps mod 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_control #(
  parameter int ALUOP_W = 2,
  parameter bit ADDI_EN = 1'b1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               pc_write,
  output logic               pc_write_cond,
  output logic               i_or_d,
  output logic               mem_read,
  output logic               mem_write,
  output logic               ir_write,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               reg_write,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [1:0]         pc_source,
  output logic               illegal_op,
  output logic [3:0]         state
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]   instr_count,
  output logic [CNT_W-1:0]   stall_count
`endif
);

  // Memory handshake: a state that requests memory (FETCH read, MEM_RD read,
  // MEM_WR write) keeps its request asserted and stays put until mem_ready is
  // high in a cycle; that cycle completes the access and the FSM moves on.
  // mem_ready is don't-care in every other state.

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    EXEC     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11,
    TRAP     = 4'd12
  } stateT;

  // Everything that is a pure function of the state. The FETCH-only
  // ir_write / pc_write pulse is not in here because it also needs mem_ready.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
  } ctrlT;

  stateT stateQ;
  stateT stateNext;
  ctrlT  ctrlQ;
  logic  fetchFire;

  // Per-state control word. Unused encodings fall to the all-zero default.
  function automatic ctrlT decodeCtrl(input stateT s);
    ctrlT c;
    c = '0;
    case (s)
      FETCH: begin
        c.memRead = 1'b1;
        c.aluSrcB = 2'd1;
      end
      DECODE: begin
        c.aluSrcB = 2'd3;           // branch target precompute
      end
      MEM_ADDR: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'd2;
      end
      MEM_RD: begin
        c.memRead = 1'b1;
        c.iOrD    = 1'b1;
      end
      MEM_WB: begin
        c.regWrite = 1'b1;
        c.memToReg = 1'b1;
      end
      MEM_WR: begin
        c.memWrite = 1'b1;
        c.iOrD     = 1'b1;
      end
      EXEC: begin
        c.aluSrcA = 1'b1;
        c.aluOp   = 2'd2;
      end
      R_WB: begin
        c.regWrite = 1'b1;
        c.regDst   = 1'b1;
      end
      BRANCH: begin
        c.aluSrcA     = 1'b1;
        c.aluOp       = 2'd1;
        c.pcWriteCond = 1'b1;
        c.pcSource    = 2'd1;
      end
      JUMP: begin
        c.pcWrite  = 1'b1;
        c.pcSource = 2'd2;
      end
      ADDI_EX: begin
        c.aluSrcA = 1'b1;
        c.aluSrcB = 2'd2;
      end
      ADDI_WB: begin
        c.regWrite = 1'b1;
      end
      TRAP: begin
        c.illegalOp = 1'b1;          // PC already advanced in FETCH
      end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Next-state logic.
  always_comb begin
    stateNext = FETCH;
    case (stateQ)
      FETCH:   stateNext = mem_ready ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     stateNext = EXEC;
          OP_LW, OP_SW: stateNext = MEM_ADDR;
          OP_BEQ:       stateNext = BRANCH;
          OP_J:         stateNext = JUMP;
          OP_ADDI:      stateNext = ADDI_EN ? ADDI_EX : TRAP;
          default:      stateNext = TRAP;
        endcase
      end
      // Opcode is looked at again here; anything other than lw/sw means the
      // IR changed underneath us, which is treated as an illegal instruction.
      MEM_ADDR: begin
        if (opcode == OP_LW)      stateNext = MEM_RD;
        else if (opcode == OP_SW) stateNext = MEM_WR;
        else                      stateNext = TRAP;
      end
      MEM_RD:  stateNext = mem_ready ? MEM_WB : MEM_RD;
      MEM_WB:  stateNext = FETCH;
      MEM_WR:  stateNext = mem_ready ? FETCH : MEM_WR;
      EXEC:    stateNext = R_WB;
      R_WB:    stateNext = FETCH;
      BRANCH:  stateNext = FETCH;
      JUMP:    stateNext = FETCH;
      ADDI_EX: stateNext = ADDI_WB;
      ADDI_WB: stateNext = FETCH;
      TRAP:    stateNext = FETCH;
      default: stateNext = FETCH;
    endcase
  end

  // State register. The control word is registered from the next state, so
  // ctrlQ always equals decodeCtrl(stateQ) without any output decode logic
  // sitting behind the flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateQ <= FETCH;
      ctrlQ  <= decodeCtrl(FETCH);
    end else begin
      stateQ <= stateNext;
      ctrlQ  <= decodeCtrl(stateNext);
    end
  end

  // FETCH completes when memory answers: load IR and PC+4 in that cycle only.
  assign fetchFire = (stateQ == FETCH) && mem_ready;

  assign pc_write      = ctrlQ.pcWrite | fetchFire;
  assign pc_write_cond = ctrlQ.pcWriteCond;
  assign i_or_d        = ctrlQ.iOrD;
  assign mem_read      = ctrlQ.memRead;
  assign mem_write     = ctrlQ.memWrite;
  assign ir_write      = fetchFire;
  assign mem_to_reg    = ctrlQ.memToReg;
  assign reg_dst       = ctrlQ.regDst;
  assign reg_write     = ctrlQ.regWrite;
  assign alu_src_a     = ctrlQ.aluSrcA;
  assign alu_src_b     = ctrlQ.aluSrcB;
  assign alu_op        = ALUOP_W'(ctrlQ.aluOp);
  assign pc_source     = ctrlQ.pcSource;
  assign illegal_op    = ctrlQ.illegalOp;
  assign state         = stateQ;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic isTerminal;
  logic isMemWait;

  // Terminal states are the last step of an instruction; leaving one for
  // FETCH retires the instruction (a trapped one included).
  always_comb begin
    isTerminal = 1'b0;
    case (stateQ)
      MEM_WB, MEM_WR, R_WB, BRANCH, JUMP, ADDI_WB, TRAP: isTerminal = 1'b1;
      default:                                          isTerminal = 1'b0;
    endcase
  end

  assign isMemWait = ((stateQ == FETCH) || (stateQ == MEM_RD) ||
                      (stateQ == MEM_WR)) && !mem_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
      stall_count <= '0;
    end else begin
      if (isTerminal && (stateNext == FETCH)) instr_count <= instr_count + CNT_W'(1);
      if (isMemWait)                          stall_count <= stall_count + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A (ADDI_EN=1, default widths) ----------------
  logic       rst_n, mem_ready;
  logic [5:0] opcode;
  logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic [3:0] state;

  // ---------------- DUT B (ADDI_EN=0, CNT_W=4) ----------------
  logic       rstB_n, readyB;
  logic [5:0] opB;
  logic       pcWriteB, pcWriteCondB, iOrDB, memReadB, memWriteB, irWriteB;
  logic       memToRegB, regDstB, regWriteB, aluSrcAB, illegalOpB;
  logic [1:0] aluSrcBB, aluOpB, pcSourceB;
  logic [3:0] stateB;

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic [31:0] instr_count, stall_count;
  logic [3:0]  instrCountB, stallCountB;
`endif

  multicycle_control #(.ALUOP_W(2), .ADDI_EN(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal_op(illegal_op), .state(state)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .instr_count(instr_count), .stall_count(stall_count)
`endif
  );

  multicycle_control #(.ALUOP_W(2), .ADDI_EN(1'b0), .CNT_W(4)) dutNoAddi (
    .clk(clk), .rst_n(rstB_n), .opcode(opB), .mem_ready(readyB),
    .pc_write(pcWriteB), .pc_write_cond(pcWriteCondB), .i_or_d(iOrDB),
    .mem_read(memReadB), .mem_write(memWriteB), .ir_write(irWriteB),
    .mem_to_reg(memToRegB), .reg_dst(regDstB), .reg_write(regWriteB),
    .alu_src_a(aluSrcAB), .alu_src_b(aluSrcBB), .alu_op(aluOpB),
    .pc_source(pcSourceB), .illegal_op(illegalOpB), .state(stateB)
`ifdef MULTICYCLE_CTRL_PERF_EN
    , .instr_count(instrCountB), .stall_count(stallCountB)
`endif
  );

  // Output bundle used for whole-vector comparisons.
  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iOrD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
    logic       illegalOp;
    logic [3:0] st;
  } outsT;

  outsT actA, actB;
  assign actA = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                 mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                 pc_source, illegal_op, state};
  assign actB = {pcWriteB, pcWriteCondB, iOrDB, memReadB, memWriteB, irWriteB,
                 memToRegB, regDstB, regWriteB, aluSrcAB, aluSrcBB, aluOpB,
                 pcSourceB, illegalOpB, stateB};

  // ---------------- scoreboard bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    exp_q.push_back(exp);
    checks++;
    if (act !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Step sequence of each instruction class, as state numbers.
  function automatic int classPath(input logic [5:0] op, input bit addiEn, input int idx);
    int p[5];
    int n;
    p = '{0, 1, 12, 0, 0};
    n = 3;
    case (op)
      OP_R:    begin p = '{0, 1, 6, 7, 0};  n = 4; end
      OP_LW:   begin p = '{0, 1, 2, 3, 4};  n = 5; end
      OP_SW:   begin p = '{0, 1, 2, 5, 0};  n = 4; end
      OP_BEQ:  begin p = '{0, 1, 8, 0, 0};  n = 3; end
      OP_J:    begin p = '{0, 1, 9, 0, 0};  n = 3; end
      OP_ADDI: if (addiEn) begin p = '{0, 1, 10, 11, 0}; n = 4; end
      default: ;
    endcase
    return (idx < n) ? p[idx] : -1;
  endfunction

  function automatic bit isMemStep(input int s);
    return (s == 0) || (s == 3) || (s == 5);
  endfunction

  // Expected outputs of one step (mem_ready matters only in FETCH).
  function automatic outsT expOuts(input int s, input logic rdy);
    outsT o;
    o = '0;
    o.st = 4'(s);
    case (s)
      0:  begin o.memRead = 1; o.aluSrcB = 2'd1; o.irWrite = rdy; o.pcWrite = rdy; end
      1:  o.aluSrcB = 2'd3;
      2:  begin o.aluSrcA = 1; o.aluSrcB = 2'd2; end
      3:  begin o.memRead = 1; o.iOrD = 1; end
      4:  begin o.regWrite = 1; o.memToReg = 1; end
      5:  begin o.memWrite = 1; o.iOrD = 1; end
      6:  begin o.aluSrcA = 1; o.aluOp = 2'd2; end
      7:  begin o.regWrite = 1; o.regDst = 1; end
      8:  begin o.aluSrcA = 1; o.aluOp = 2'd1; o.pcWriteCond = 1; o.pcSource = 2'd1; end
      9:  begin o.pcWrite = 1; o.pcSource = 2'd2; end
      10: begin o.aluSrcA = 1; o.aluSrcB = 2'd2; end
      11: o.regWrite = 1;
      12: o.illegalOp = 1;
      default: ;
    endcase
    return o;
  endfunction

  int pos    = 0;   // step index within the current instruction of DUT A
  int mInstr = 0;   // instructions completed by DUT A since reset
  int mStall = 0;   // memory wait cycles of DUT A since reset

  // One clock of DUT A: drive, check at negedge, advance model after posedge.
  task automatic doCycle(input logic [5:0] op, input logic rdy);
    int s;
    opcode    = op;
    mem_ready = rdy;
    @(negedge clk);
    s = classPath(op, 1'b1, pos);
    chk($sformatf("outs op=%b step=%0d", op, s), 32'(actA), 32'(expOuts(s, rdy)));
    @(posedge clk);
    #1;
    if (isMemStep(s) && !rdy) begin
      mStall++;
    end else begin
      pos++;
      if (classPath(op, 1'b1, pos) < 0) begin
        pos = 0;
        mInstr++;
      end
    end
  endtask

  // Runs one complete instruction on DUT A.
  task automatic runInstr(input logic [5:0] op, input int fWaits, input int dWaits,
                          input bit rnd, output int cycles);
    int s;
    int startCount;
    logic r;
    cycles     = 0;
    startCount = mInstr;
    while (mInstr == startCount && cycles < 200) begin
      s = classPath(op, 1'b1, pos);
      if (rnd) begin
        r = ($urandom_range(0, 3) != 0);
      end else if (s == 0) begin
        r = (fWaits == 0);
        if (fWaits > 0) fWaits--;
      end else if (s == 3 || s == 5) begin
        r = (dWaits == 0);
        if (dWaits > 0) dWaits--;
      end else begin
        r = 1'($urandom_range(0, 1));   // ignored outside memory steps
      end
      doCycle(op, r);
      cycles++;
    end
    if (mInstr == startCount) begin
      checks++;
      errors++;
      $display("FAIL timeout op=%b actual=%0d cycles expected=<200", op, cycles);
    end
  endtask

  // One clock of DUT B against an explicit expected step.
  task automatic cycleB(input logic [5:0] op, input logic rdy, input int expS);
    opB    = op;
    readyB = rdy;
    @(negedge clk);
    chk($sformatf("noaddi op=%b step=%0d", op, expS), 32'(actB), 32'(expOuts(expS, rdy)));
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    string      name;
    logic [5:0] op;
    int         dWaits;
    int         expCycles;
  } vecT;

  vecT tbl[8];

  initial begin
    int cyc;
    logic [5:0] op;

    tbl[0] = '{"rtype",    OP_R,    0, 4};
    tbl[1] = '{"lw_wait2", OP_LW,   2, 7};
    tbl[2] = '{"sw_wait1", OP_SW,   1, 5};
    tbl[3] = '{"beq",      OP_BEQ,  0, 3};
    tbl[4] = '{"jump",     OP_J,    0, 3};
    tbl[5] = '{"addi",     OP_ADDI, 0, 4};
    tbl[6] = '{"illegal",  OP_BAD,  0, 3};
    tbl[7] = '{"lw",       OP_LW,   0, 5};

    rst_n = 1'b0; mem_ready = 1'b0; opcode = '0;
    rstB_n = 1'b0; readyB = 1'b0; opB = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", 32'(actA), 32'(expOuts(0, 1'b0)));
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("reset_instr_count", instr_count, 32'd0);
    chk("reset_stall_count", stall_count, 32'd0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Table: latency per class plus per-cycle output checks.
    for (int i = 0; i < 8; i++) begin
      runInstr(tbl[i].op, 0, tbl[i].dWaits, 1'b0, cyc);
      chk({"latency_", tbl[i].name}, 32'(cyc), 32'(tbl[i].expCycles));
    end

    // Reset in the middle of a stalled sw.
    doCycle(OP_SW, 1'b1);
    doCycle(OP_SW, 1'b0);
    doCycle(OP_SW, 1'b1);
    doCycle(OP_SW, 1'b0);
    chk("pre_reset_state", 32'(state), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_outs", 32'(actA), 32'(expOuts(0, 1'b0)));
    chk("async_reset_memwrite", 32'(mem_write), 32'd0);
    pos = 0; mInstr = 0; mStall = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    runInstr(OP_R, 0, 0, 1'b0, cyc);   // first FETCH fires immediately
    runInstr(OP_R, 2, 0, 1'b0, cyc);
    runInstr(OP_R, 2, 0, 1'b0, cyc);
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_instr_3", instr_count, 32'd3);
    chk("perf_stall_4", stall_count, 32'd4);
`endif

    // Randomized instruction stream with random memory waits.
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 7))
        0:       op = OP_R;
        1:       op = OP_LW;
        2:       op = OP_SW;
        3:       op = OP_BEQ;
        4:       op = OP_J;
        5:       op = OP_ADDI;
        default: op = 6'($urandom_range(0, 63));
      endcase
      runInstr(op, 0, 0, 1'b1, cyc);
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("perf_instr_model", instr_count, 32'(mInstr));
    chk("perf_stall_model", stall_count, 32'(mStall));
`endif

    // ADDI_EN=0 instance: addi and an undefined opcode both trap.
    rstB_n = 1'b1;
    cycleB(OP_ADDI, 1'b1, 0);
    cycleB(OP_ADDI, 1'b1, 1);
    cycleB(OP_ADDI, 1'b1, 12);
    cycleB(OP_BAD,  1'b1, 0);
    cycleB(OP_BAD,  1'b1, 1);
    cycleB(OP_BAD,  1'b0, 12);
    cycleB(OP_R,    1'b0, 0);      // trap pulse is over, FETCH stalls
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("noaddi_instr_2", 32'(instrCountB), 32'd2);
    chk("noaddi_stall_1", 32'(stallCountB), 32'd1);
`endif
    rstB_n = 1'b0;
    #1;
    rstB_n = 1'b1;
    for (int k = 0; k < 17; k++) begin
      cycleB(OP_R, 1'b1, 0);
      cycleB(OP_R, 1'b1, 1);
      cycleB(OP_R, 1'b1, 6);
      cycleB(OP_R, 1'b1, 7);
    end
`ifdef MULTICYCLE_CTRL_PERF_EN
    chk("cnt4_wrap_instr", 32'(instrCountB), 32'd1);
    chk("cnt4_wrap_stall", 32'(stallCountB), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
